// File: rtl/uncache_pkg.sv
// uncache_pkg: shared FSM state encoding and AXI field constants for the
// uncached-access AXI bridge (uncache_axi).
package uncache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AWW,
    WR_B,
    DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;

endpackage

// File: rtl/uncache_axi.sv
// uncache_axi: turns a single-beat uncached load/store request into one AXI
// transaction (AR/R for reads, AW/W/B for writes).
//
// Ports
//   aclk, aresetn            clock (rising edge), async active-low reset
//   uncache_*                upstream request side: req/wreq/addr/din/wbyte
//                            held until uncache_ok; uncache_data = read data
//   ar*/r*/aw*/w*/b*         AXI master channels, single-beat INCR bursts
//
// Build option
//   UNCACHE_WBUF_EN          posted writes: ok the cycle after a write is
//                            accepted, AW/W/B finish in the background and
//                            any new request stalls until B returns.
module uncache_axi #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] uncache_addr,
  input  logic [31:0] uncache_din,
  output logic [31:0] uncache_data,
  input  logic        uncache_req,
  input  logic        uncache_wreq,
  input  logic [3:0]  uncache_wbyte,
  output logic        uncache_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  import uncache_pkg::*;

  function automatic logic [2:0] awsize_of(input logic [3:0] wb);
    case (wb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize_of = SIZE_B;
      4'b0011, 4'b1100:                   awsize_of = SIZE_H;
      default:                            awsize_of = SIZE_W;
    endcase
  endfunction

  state_t      state_q, state_d;
  state_t      wr_st, wr_nx;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [3:0]  wbyte_q, wbyte_d;
  logic [31:0] data_q, data_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        wb_busy;
  logic        aw_hs, w_hs;
  logic        unused_inputs;

  // The write engine (WR_AWW/WR_B) is the main FSM in the default build and
  // a separate background state register when writes are posted.
`ifdef UNCACHE_WBUF_EN
  localparam state_t WR_ACCEPT = DONE;
  localparam state_t WR_END    = IDLE;
  state_t wb_state_q, wb_state_d;
  assign wr_st   = wb_state_q;
  assign wb_busy = (wb_state_q != IDLE);
`else
  localparam state_t WR_ACCEPT = WR_AWW;
  localparam state_t WR_END    = DONE;
  assign wr_st   = state_q;
  assign wb_busy = 1'b0;
`endif

  assign unused_inputs = ^{rid, rresp, bid, bresp};

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = '0;
  assign arsize  = SIZE_W;
  assign arburst = BURST_INCR;
  assign arvalid = (state_q == RD_AR);
  assign rready  = (state_q == RD_R);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = '0;
  assign awsize  = awsize_of(wbyte_q);
  assign awburst = BURST_INCR;
  assign awvalid = (wr_st == WR_AWW) && !aw_done_q;
  assign wid     = AXI_ID;
  assign wdata   = din_q;
  assign wstrb   = wbyte_q;
  assign wlast   = 1'b1;
  assign wvalid  = (wr_st == WR_AWW) && !w_done_q;
  assign bready  = (wr_st == WR_B);

  assign uncache_ok   = (state_q == DONE);
  assign uncache_data = data_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wbyte_d   = wbyte_q;
    data_d    = data_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_nx     = wr_st;

    // AW and W complete independently; leave WR_AWW once both have gone,
    // counting a handshake happening this very cycle.
    case (wr_st)
      WR_AWW: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          wr_nx     = WR_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
        end
      end
      WR_B:    if (bvalid) wr_nx = WR_END;
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (uncache_req && !wb_busy) begin
          addr_d  = uncache_addr;
          din_d   = uncache_din;
          wbyte_d = uncache_wbyte;
          state_d = uncache_wreq ? WR_ACCEPT : RD_AR;
        end
      end
      RD_AR:        if (arready) state_d = RD_R;
      RD_R: begin
        if (rvalid && rlast) begin
          data_d  = rdata;
          state_d = DONE;
        end
      end
      WR_AWW, WR_B: state_d = wr_nx;
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase

`ifdef UNCACHE_WBUF_EN
    wb_state_d = wr_nx;
    if (state_q == IDLE && uncache_req && uncache_wreq && !wb_busy)
      wb_state_d = WR_AWW;
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      wbyte_q   <= '0;
      data_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef UNCACHE_WBUF_EN
      wb_state_q <= IDLE;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wbyte_q   <= wbyte_d;
      data_q    <= data_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef UNCACHE_WBUF_EN
      wb_state_q <= wb_state_d;
`endif
    end
  end

endmodule

// File: tb/tb_uncache_axi.sv
// tb_uncache_axi: directed self-checking bench for uncache_axi. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// Write tests follow the build: acknowledged-after-B by default, posted
// writes when UNCACHE_WBUF_EN is defined.
module tb_uncache_axi;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] uncache_addr, uncache_din, uncache_data;
  logic        uncache_req, uncache_wreq, uncache_ok;
  logic [3:0]  uncache_wbyte;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;
  int aw_cnt, w_cnt, ok_cnt;

  always #5 aclk = ~aclk;

  uncache_axi #(.AXI_ID(4'd1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .uncache_addr(uncache_addr), .uncache_din(uncache_din),
    .uncache_data(uncache_data), .uncache_req(uncache_req),
    .uncache_wreq(uncache_wreq), .uncache_wbyte(uncache_wbyte),
    .uncache_ok(uncache_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Records handshakes that complete at the coming edge, then advances.
  task automatic step();
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready) w_cnt++;
    if (uncache_ok) ok_cnt++;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    uncache_addr = '0; uncache_din = '0; uncache_req = 1'b0;
    uncache_wreq = 1'b0; uncache_wbyte = '0;
    arready = 1'b0; rid = 4'd1; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    idle_inputs();
    aw_cnt = 0; w_cnt = 0; ok_cnt = 0;
    step(); step();
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, uncache_ok} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {arvalid, rready, awvalid, wvalid, bready, uncache_ok});
    end
    total++;
    if (uncache_data !== 32'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=00000000", uncache_data);
    end
    aresetn = 1'b1;
    step();
    total++;
    if ({arvalid, awvalid, uncache_ok} !== 3'b000) begin
      bad++; $display("FAIL reset_idle got=%b exp=000", {arvalid, awvalid, uncache_ok});
    end
  endtask

  task automatic test_read();
    uncache_addr = 32'h1faf_f020; uncache_wreq = 1'b0; uncache_req = 1'b1;
    arready = 1'b1;
    step();
    total++;
    if ({arvalid, rready, uncache_ok} !== 3'b100) begin
      bad++; $display("FAIL rd_ar_ctrl got=%b exp=100", {arvalid, rready, uncache_ok});
    end
    total++;
    if (araddr !== 32'h1faf_f020) begin
      bad++; $display("FAIL rd_araddr got=%h exp=1faff020", araddr);
    end
    total++;
    if ({arid, arlen, arsize, arburst} !== {4'd1, 8'd0, 3'd2, 2'b01}) begin
      bad++; $display("FAIL rd_ar_fields got=%h exp=%h",
                      {arid, arlen, arsize, arburst}, {4'd1, 8'd0, 3'd2, 2'b01});
    end
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h0000_00ff;
    step();
    total++;
    if ({arvalid, rready, uncache_ok} !== 3'b010) begin
      bad++; $display("FAIL rd_r_ctrl got=%b exp=010", {arvalid, rready, uncache_ok});
    end
    step();
    total++;
    if ({uncache_ok, uncache_data} !== {1'b1, 32'h0000_00ff}) begin
      bad++; $display("FAIL rd_done got=%b/%h exp=1/000000ff", uncache_ok, uncache_data);
    end
    uncache_req = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 32'hdead_beef;
    arready = 1'b0;
    step();
    total++;
    if ({uncache_ok, uncache_data} !== {1'b0, 32'h0000_00ff}) begin
      bad++; $display("FAIL rd_hold got=%b/%h exp=0/000000ff", uncache_ok, uncache_data);
    end
  endtask

`ifndef UNCACHE_WBUF_EN
  task automatic test_byte_write();
    uncache_addr = 32'h1faf_0104; uncache_din = 32'h00ab_0000;
    uncache_wbyte = 4'b0100; uncache_wreq = 1'b1; uncache_req = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    step();
    total++;
    if ({awvalid, wvalid, wlast} !== 3'b111) begin
      bad++; $display("FAIL wb_valid got=%b exp=111", {awvalid, wvalid, wlast});
    end
    total++;
    if ({awsize, wstrb} !== {3'd0, 4'b0100}) begin
      bad++; $display("FAIL wb_size_strb got=%0d/%b exp=0/0100", awsize, wstrb);
    end
    total++;
    if ({awaddr, wdata} !== {32'h1faf_0104, 32'h00ab_0000}) begin
      bad++; $display("FAIL wb_addr_data got=%h/%h exp=1faf0104/00ab0000", awaddr, wdata);
    end
    total++;
    if ({awid, wid, awlen, awburst} !== {4'd1, 4'd1, 8'd0, 2'b01}) begin
      bad++; $display("FAIL wb_fields got=%h exp=%h",
                      {awid, wid, awlen, awburst}, {4'd1, 4'd1, 8'd0, 2'b01});
    end
    step();
    total++;
    if ({awvalid, wvalid, bready, uncache_ok} !== 4'b0010) begin
      bad++; $display("FAIL wb_b_ctrl got=%b exp=0010", {awvalid, wvalid, bready, uncache_ok});
    end
    step(); step();
    total++;
    if ({bready, uncache_ok} !== 2'b10) begin
      bad++; $display("FAIL wb_wait_b got=%b exp=10", {bready, uncache_ok});
    end
    bvalid = 1'b1;
    step();
    total++;
    if ({bready, uncache_ok} !== 2'b01) begin
      bad++; $display("FAIL wb_done got=%b exp=01", {bready, uncache_ok});
    end
    bvalid = 1'b0; uncache_req = 1'b0; awready = 1'b0; wready = 1'b0;
    step();
    total++;
    if (uncache_ok !== 1'b0) begin
      bad++; $display("FAIL wb_ok_pulse got=%b exp=0", uncache_ok);
    end
  endtask

  task automatic test_w_before_aw();
    uncache_addr = 32'h1faf_0200; uncache_din = 32'h1234_5678;
    uncache_wbyte = 4'b1100; uncache_wreq = 1'b1; uncache_req = 1'b1;
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0;
    aw_cnt = 0; w_cnt = 0; ok_cnt = 0;
    step();
    total++;
    if ({awsize, awvalid, wvalid} !== {3'd1, 2'b11}) begin
      bad++; $display("FAIL wa_entry got=%0d/%b%b exp=1/11", awsize, awvalid, wvalid);
    end
    step();
    total++;
    if ({awvalid, wvalid} !== 2'b10) begin
      bad++; $display("FAIL wa_w_taken got=%b exp=10", {awvalid, wvalid});
    end
    step();
    total++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      bad++; $display("FAIL wa_aw_wait got=%b exp=100", {awvalid, wvalid, bready});
    end
    awready = 1'b1;
    step();
    total++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      bad++; $display("FAIL wa_b_phase got=%b exp=001", {awvalid, wvalid, bready});
    end
    awready = 1'b0; bvalid = 1'b1;
    step();
    total++;
    if (uncache_ok !== 1'b1) begin
      bad++; $display("FAIL wa_ok got=%b exp=1", uncache_ok);
    end
    bvalid = 1'b0; uncache_req = 1'b0; wready = 1'b0;
    step(); step();
    total++;
    if ({aw_cnt, w_cnt, ok_cnt} !== {32'd1, 32'd1, 32'd1}) begin
      bad++; $display("FAIL wa_counts got=aw%0d w%0d ok%0d exp=aw1 w1 ok1", aw_cnt, w_cnt, ok_cnt);
    end
  endtask

  task automatic test_back_to_back();
    uncache_addr = 32'h1faf_0300; uncache_din = 32'hcafe_f00d;
    uncache_wbyte = 4'b1111; uncache_wreq = 1'b1; uncache_req = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    step();
    total++;
    if (awsize !== 3'd2) begin
      bad++; $display("FAIL bb_awsize got=%0d exp=2", awsize);
    end
    step(); step();
    total++;
    if (uncache_ok !== 1'b1) begin
      bad++; $display("FAIL bb_w_ok got=%b exp=1", uncache_ok);
    end
    // Request switches to a read while ok is high; it must not be taken yet.
    uncache_wreq = 1'b0; uncache_addr = 32'h1faf_f040; bvalid = 1'b0;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rdata = 32'ha5a5_5a5a;
    step();
    total++;
    if ({uncache_ok, arvalid} !== 2'b00) begin
      bad++; $display("FAIL bb_gap got=%b exp=00", {uncache_ok, arvalid});
    end
    step();
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h1faf_f040}) begin
      bad++; $display("FAIL bb_ar got=%b/%h exp=1/1faff040", arvalid, araddr);
    end
    step(); step();
    total++;
    if ({uncache_ok, uncache_data} !== {1'b1, 32'ha5a5_5a5a}) begin
      bad++; $display("FAIL bb_rd_done got=%b/%h exp=1/a5a55a5a", uncache_ok, uncache_data);
    end
    idle_inputs();
    step();
  endtask
`else
  task automatic test_wbuf_posted();
    uncache_addr = 32'h1faf_0300; uncache_din = 32'hcafe_f00d;
    uncache_wbyte = 4'b1111; uncache_wreq = 1'b1; uncache_req = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    step();
    total++;
    if ({uncache_ok, awvalid, wvalid} !== 3'b111) begin
      bad++; $display("FAIL pw_ok got=%b exp=111", {uncache_ok, awvalid, wvalid});
    end
    uncache_wreq = 1'b0; uncache_addr = 32'h1faf_f050; arready = 1'b1;
    step();
    total++;
    if ({uncache_ok, arvalid, bready} !== 3'b001) begin
      bad++; $display("FAIL pw_b_phase got=%b exp=001", {uncache_ok, arvalid, bready});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({uncache_ok, arvalid, bready} !== 3'b001) begin
        bad++; $display("FAIL pw_stall[%0d] got=%b exp=001", i, {uncache_ok, arvalid, bready});
      end
    end
    bvalid = 1'b1;
    step();
    total++;
    if ({arvalid, bready} !== 2'b00) begin
      bad++; $display("FAIL pw_b_done got=%b exp=00", {arvalid, bready});
    end
    bvalid = 1'b0;
    step();
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h1faf_f050}) begin
      bad++; $display("FAIL pw_ar got=%b/%h exp=1/1faff050", arvalid, araddr);
    end
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h3c3c_c3c3;
    step(); step();
    total++;
    if ({uncache_ok, uncache_data} !== {1'b1, 32'h3c3c_c3c3}) begin
      bad++; $display("FAIL pw_rd_done got=%b/%h exp=1/3c3cc3c3", uncache_ok, uncache_data);
    end
    idle_inputs();
    step();
  endtask
`endif

  task automatic test_reset_mid();
    uncache_addr = 32'h1faf_f030; uncache_wreq = 1'b0; uncache_req = 1'b1;
    arready = 1'b1; rvalid = 1'b0;
    step(); step();
    total++;
    if (rready !== 1'b1) begin
      bad++; $display("FAIL rm_in_r got=%b exp=1", rready);
    end
    #1 aresetn = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, uncache_ok, uncache_data} !== {3'b000, 32'h0}) begin
      bad++; $display("FAIL rm_async got=%b%b%b/%h exp=000/00000000",
                      arvalid, rready, uncache_ok, uncache_data);
    end
    step();
    total++;
    if ({arvalid, rready, uncache_ok} !== 3'b000) begin
      bad++; $display("FAIL rm_held got=%b exp=000", {arvalid, rready, uncache_ok});
    end
    uncache_addr = 32'h0000_1234;
    aresetn = 1'b1;
    step();
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_1234}) begin
      bad++; $display("FAIL rm_new_ar got=%b/%h exp=1/00001234", arvalid, araddr);
    end
    rvalid = 1'b1; rlast = 1'b1; rdata = 32'h1234_5678;
    step(); step();
    total++;
    if ({uncache_ok, uncache_data} !== {1'b1, 32'h1234_5678}) begin
      bad++; $display("FAIL rm_new_done got=%b/%h exp=1/12345678", uncache_ok, uncache_data);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_read();
`ifndef UNCACHE_WBUF_EN
    test_byte_write();
    test_w_before_aw();
    test_back_to_back();
`else
    test_wbuf_posted();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uncache_axi.md
UNCACHE_AXI -- requirements
Module: uncache_axi

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1: ID driven on arid/awid/wid.
REQ-002 SHALL have port aclk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port aresetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port uncache_addr, input, 32: request address from the cache/uncache splitter.
REQ-005 SHALL have ports uncache_din (input, 32), uncache_data (output, 32): write data and read return data.
REQ-006 SHALL have ports uncache_req, uncache_wreq (input, 1 each): request and write-not-read.
REQ-007 SHALL have ports uncache_wbyte (input, 4), uncache_ok (output, 1): byte enables and completion pulse.
REQ-008 SHALL have AR ports arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0], arburst[1:0], arvalid as outputs, and arready as input.
REQ-009 SHALL have R ports rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid as inputs, and rready as output.
REQ-010 SHALL have AW ports awid, awaddr, awlen, awsize, awburst, awvalid as outputs (AR widths), and awready as input.
REQ-011 SHALL have W ports wid[3:0], wdata[31:0], wstrb[3:0], wlast, wvalid as outputs, wready as input; B ports bid[3:0], bresp[1:0], bvalid as inputs, bready as output.

Function
REQ-012 SHALL treat uncache_req as a level held by upstream, with stable addr/din/wreq/wbyte, until the cycle uncache_ok=1.
REQ-013 SHALL use FSM states IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE.
REQ-014 SHALL, in IDLE with uncache_req=1, register addr/din/wbyte and go to RD_AR (wreq=0) or WR_AWW (wreq=1).
REQ-015 SHALL hold arvalid=1 in RD_AR until arready, then enter RD_R with rready=1.
REQ-016 SHALL capture rdata into uncache_data on rvalid&rready&rlast and enter DONE; rresp is ignored.
REQ-017 SHALL assert awvalid and wvalid together on entry to WR_AWW, drop each independently on its own handshake, and enter WR_B once both are done, in either order or the same cycle.
REQ-018 SHALL assert bready in WR_B and enter DONE on bvalid; bresp is ignored.
REQ-019 SHALL pulse uncache_ok=1 for exactly one cycle in DONE, then return to IDLE; the next request is not sampled before the following cycle.
REQ-020 SHALL drive arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=3'd2, wdata=latched din, wstrb=latched wbyte.
REQ-021 SHALL derive awsize from wbyte: one bit set -> 0; 4'b0011 or 4'b1100 -> 1; otherwise -> 2.
REQ-022 SHALL keep araddr/awaddr equal to the latched address, and hold uncache_data until the next read completes.
REQ-023 SHALL allow minimum latency IDLE->ok of 3 cycles for a read and 3 cycles for a write when all ready/valid inputs are 1.

Reset
REQ-024 SHALL, on aresetn=0 at any time including mid-transaction, force IDLE and drive all valid/ready outputs, uncache_ok and uncache_data to 0.
REQ-025 SHALL drop an interrupted AXI transaction without completing it; the interconnect is reset together with this block.

Configuration
REQ-026 SHALL, with UNCACHE_WBUF_EN defined, pulse uncache_ok the cycle after accepting a write (posted write) and complete AW/W/B in the background.
REQ-027 SHALL, with UNCACHE_WBUF_EN defined, stall any new request (no ok) while a posted write has not yet received B.
REQ-028 SHALL, without UNCACHE_WBUF_EN, acknowledge writes only after B per REQ-018.

Structure
REQ-029 SHALL place FSM state encodings and AXI constants (BURST_INCR, SIZE_W/H/B) in shared package uncache_pkg.
REQ-030 SHALL be a single module with no sub-module; awsize decode is an inline function.

Verification
REQ-031 SHALL verify read: addr 32'h1faf_f020, arready=1, rdata=32'h0000_00ff with rlast -> araddr=1faff020, arsize=2, uncache_data=000000ff with ok pulse 3 cycles after req.
REQ-032 SHALL verify byte write: wbyte=4'b0100, din=32'h00ab_0000 -> awsize=0, wstrb=0100, ok only after bvalid.
REQ-033 SHALL verify W handshake two cycles before AW -> single AW and single W beat, then B, then one ok pulse.
REQ-034 SHALL verify aresetn=0 in RD_R -> arvalid/rready/ok=0 and IDLE; a new read after reset completes normally.
REQ-035 SHALL verify with UNCACHE_WBUF_EN: write then immediate read, bvalid delayed 5 cycles -> write ok after 1 cycle; arvalid not raised until B done.
